dm_io_periph: RTL
=================

Name: dm_io_periph

Overview:
- Memory-mapped I/O peripheral on the same load/store bus as the data memory, decoded just above the 1 KiB data RAM (0x000–0x3FF).
- Owns the board LED register and a synchronised, debounced view of the 10 slide switches, plus sticky switch-change flags.
- Honours the data-memory access-size encoding so the CPU uses its normal byte, half and word loads and stores.
- The top-level read mux selects DataRd from this block when sel=1.

Parameters:
- BASE_ADDR, 32'h0000_0400: base of the 16-byte I/O window. Bits [3:0] are zero.
- SW_W, 10: number of switch and LED bits.
- DEB_CYCLES, 500000: stable cycles required before a switch change is accepted (10 ms at 50 MHz). Minimum value is 2.

Ports:
- clk, input, 1: system clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- Address, input, 32: byte address from the ALU.
- DataWr, input, 32: store data.
- DMWr, input, 1: store strobe.
- DMCtrl, input, 3: access size. 000=B, 001=H, 010=W, 100=BU, 101=HU; other codes are invalid.
- sw, input, SW_W: raw asynchronous switch inputs.
- DataRd, output, 32: load data, combinational.
- sel, output, 1: combinational address hit, Address[31:4]==BASE_ADDR[31:4].
- Leds, output, SW_W: LED register, driven directly from a flop.

Behaviour:
- Register map, word index Address[3:2]:
  - 0 LED: RW, bits [SW_W-1:0]; upper bits read 0.
  - 1 SW: RO, debounced switch state.
  - 2 FLAGS: bit i sticky-set on any accepted change of debounced sw[i]; write-1-to-clear.
  - 3: reserved; reads 0, writes ignored.
- Alignment:
  - B is always aligned.
  - H requires Address[0]=0.
  - W requires Address[1:0]=0.
  - Misaligned or invalid-code accesses change no state, and DataRd=0.
- Writes (DMWr && sel && aligned && valid code) take effect at the next rising edge.
  - B writes byte lane Address[1:0]; H writes lanes Address[1:0] and Address[1:0]+1; W writes all four lanes.
  - Only bits that exist in the target register change.
  - BU and HU with DMWr=1 are invalid codes for stores and are ignored.
- Reads, when sel=1 and the access is aligned and valid:
  - B: sign-extend the selected byte.
  - BU: zero-extend the selected byte.
  - H: sign-extend the selected halfword.
  - HU: zero-extend the selected halfword.
  - W: full 32-bit word.
  - sel=0 gives DataRd=0.
- Synchroniser: 2-flop chain per bit. sw_s changes 2 edges after sw.
- Debounce, per bit:
  - Counter cnt of width $clog2(DEB_CYCLES).
  - If sw_s==stable, cnt<=0.
  - Otherwise, if cnt==DEB_CYCLES-1, then stable<=sw_s and cnt<=0; else cnt<=cnt+1.
  - A change held steady is accepted on edge 2+DEB_CYCLES after the raw change.
  - A glitch shorter than DEB_CYCLES cycles at sw_s is never accepted, and cnt restarts from 0.
- FLAGS:
  - Set on the same edge that stable toggles, for either direction.
  - If a set and a W1C on the same bit occur in the same cycle, the set wins.
- Reset (rst=1 at an edge): Leds, sync flops, stable, cnt and FLAGS all go to 0.
  - Reset asserted mid-debounce discards the pending count.
  - Switches already high at reset-release are accepted after 2+DEB_CYCLES cycles and set their FLAGS bits.

Decomposition:
- Shared package dm_pkg holds:
  - DMCtrl encodings DM_B, DM_H, DM_W, DM_BU, DM_HU as localparams (3-bit).
  - Register offsets IO_LED=4'h0, IO_SW=4'h4, IO_FLAGS=4'h8.
  - The lane-extract/extend function, shared with the data memory.
- One sub-module, sw_debounce (2-flop sync, counter and stable flop; outputs stable and a change pulse), instantiated SW_W times through generate.
- Address decode, lane write enables, registers and the read mux stay in the top.

Test Plan (DEB_CYCLES=4):
- After reset, W store 0x0000_03A5 to 0x400, then W load 0x400 -> Leds=10'h3A5, DataRd=0x0000_03A5. A B load from 0x400 gives 0xFFFF_FFA5; a BU load gives 0x0000_00A5.
- With Leds=0, B store 0x02 to 0x401 -> Leds=10'h200. A H store to 0x401 (misaligned) -> Leds unchanged and DataRd=0.
- sw goes 0->0x001 and is held -> SW reads 0 through edge 5; at edge 6 SW=0x001 and FLAGS=0x001.
- sw[0] pulsed high for 3 cycles -> SW stays 0 and FLAGS stays 0.
- With FLAGS=0x003, W store 0x1 to 0x408 in the same cycle bit 1 re-sets -> FLAGS=0x002. A W store of 0xFFFF_FFFF to 0x404 -> SW unchanged.
- rst asserted for 1 cycle at cnt=2 with Leds=0x3FF -> Leds=0, FLAGS=0, and the debounce restarts from 0. Address 0x3FC gives sel=0, DataRd=0; address 0x40C reads 0.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared load/store definitions for the data-memory bus.
// Holds the DMCtrl access-size codes, the I/O register offsets and the
// lane extract/extend helper also used by the data memory read path.
package dm_pkg;

  localparam logic [2:0] DM_B  = 3'b000;
  localparam logic [2:0] DM_H  = 3'b001;
  localparam logic [2:0] DM_W  = 3'b010;
  localparam logic [2:0] DM_BU = 3'b100;
  localparam logic [2:0] DM_HU = 3'b101;

  localparam logic [3:0] IO_LED   = 4'h0;
  localparam logic [3:0] IO_SW    = 4'h4;
  localparam logic [3:0] IO_FLAGS = 4'h8;

  // Picks the byte/half addressed by lo out of a 32-bit word and extends it
  // according to ctrl. Unknown codes return 0; alignment is the caller's job.
  function automatic logic [31:0] dm_lane_extract(input logic [31:0] word,
                                                  input logic [1:0]  lo,
                                                  input logic [2:0]  ctrl);
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {lo, 3'b000};
    case (ctrl)
      DM_B:    res = {{24{sh[7]}}, sh[7:0]};
      DM_BU:   res = {24'h0, sh[7:0]};
      DM_H:    res = {{16{sh[15]}}, sh[15:0]};
      DM_HU:   res = {16'h0, sh[15:0]};
      DM_W:    res = word;
      default: res = 32'h0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dm_io_periph_if.sv
// Load/store bus between the CPU and a data-memory-mapped slave.
// master: drives Address, DataWr, DMWr, DMCtrl; receives DataRd, sel.
// slave : the reverse.
interface dm_io_periph_if;
  logic [31:0] Address;
  logic [31:0] DataWr;
  logic        DMWr;
  logic [2:0]  DMCtrl;
  logic [31:0] DataRd;
  logic        sel;

  modport master (output Address, output DataWr, output DMWr, output DMCtrl,
                  input  DataRd,  input  sel);
  modport slave  (input  Address, input  DataWr, input  DMWr, input  DMCtrl,
                  output DataRd,  output sel);
endinterface

// File: rtl/dm_io_periph_sw_debounce.sv
// One switch bit: 2-flop synchroniser followed by a debounce counter.
// Ports: clk, rst (sync, active high), i_sw (raw async switch),
//        o_stable (debounced level), o_change (high in the cycle whose
//        closing edge updates o_stable).
module sw_debounce #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_sw,
  output logic o_stable,
  output logic o_change
);

  localparam int CNT_W = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEB_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;
  logic             w_diff;

  assign w_diff = r_s2 ^ r_stable;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_s1 <= i_sw;
      r_s2 <= r_s1;
      // any return to the stable level throws away the partial count
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        r_stable <= r_s2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_stable = r_stable;
  assign o_change = w_diff && (r_cnt == LAST);

endmodule

// File: rtl/dm_io_periph.sv
// Memory-mapped I/O peripheral: LED register, debounced switches and
// sticky switch-change flags in a 16-byte window at BASE_ADDR.
// Ports: clk, rst (sync, active high); bus (load/store slave: Address,
//        DataWr, DMWr, DMCtrl in; DataRd, sel out, both combinational);
//        sw (raw switches); Leds (LED register flop).
module dm_io_periph
  import dm_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0400,
  parameter int          SW_W       = 10,
  parameter int          DEB_CYCLES = 500000
) (
  input  logic            clk,
  input  logic            rst,
  dm_io_periph_if.slave   bus,
  input  logic [SW_W-1:0] sw,
  output logic [SW_W-1:0] Leds
);

  logic [SW_W-1:0] r_leds;
  logic [SW_W-1:0] r_flags;
  logic [SW_W-1:0] w_stable;
  logic [SW_W-1:0] w_change;

  logic            w_hit;
  logic [1:0]      w_lo;
  logic [1:0]      w_idx;
  logic            w_aligned;
  logic            w_wr_ok;
  logic [31:0]     w_mask;
  logic [31:0]     w_wdata;
  logic [31:0]     w_word;
  logic [SW_W-1:0] w_wm;
  logic [SW_W-1:0] w_wd;
  logic            w_we_led;
  logic            w_we_flags;
  logic            w_unused;

  for (genvar i = 0; i < SW_W; i++) begin : g_deb
    sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk      (clk),
      .rst      (rst),
      .i_sw     (sw[i]),
      .o_stable (w_stable[i]),
      .o_change (w_change[i])
    );
  end

  always_comb begin
    w_hit     = (bus.Address[31:4] == BASE_ADDR[31:4]);
    w_lo      = bus.Address[1:0];
    w_idx     = bus.Address[3:2];
    w_aligned = 1'b0;
    w_mask    = 32'h0;
    case (bus.DMCtrl)
      DM_B, DM_BU: begin
        w_aligned = 1'b1;
        w_mask    = 32'h0000_00FF << {w_lo, 3'b000};
      end
      DM_H, DM_HU: begin
        w_aligned = !w_lo[0];
        w_mask    = 32'h0000_FFFF << {w_lo, 3'b000};
      end
      DM_W: begin
        w_aligned = (w_lo == 2'b00);
        w_mask    = 32'hFFFF_FFFF;
      end
      default: ;
    endcase
    w_wdata = bus.DataWr << {w_lo, 3'b000};

    // unsigned-load codes are not store sizes
    w_wr_ok    = bus.DMWr && w_hit && w_aligned &&
                 ((bus.DMCtrl == DM_B) || (bus.DMCtrl == DM_H) || (bus.DMCtrl == DM_W));
    w_we_led   = w_wr_ok && (w_idx == IO_LED[3:2]);
    w_we_flags = w_wr_ok && (w_idx == IO_FLAGS[3:2]);
    w_wm       = w_mask[SW_W-1:0];
    w_wd       = w_wdata[SW_W-1:0];

    w_word = 32'h0;
    case (w_idx)
      IO_LED[3:2]:   w_word[SW_W-1:0] = r_leds;
      IO_SW[3:2]:    w_word[SW_W-1:0] = w_stable;
      IO_FLAGS[3:2]: w_word[SW_W-1:0] = r_flags;
      default: ;
    endcase

    bus.sel    = w_hit;
    bus.DataRd = (w_hit && w_aligned) ? dm_lane_extract(w_word, w_lo, bus.DMCtrl) : 32'h0;
  end

  // bits above SW_W have no register behind them
  assign w_unused = ^{w_mask, w_wdata};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_leds  <= '0;
      r_flags <= '0;
    end else begin
      if (w_we_led)
        r_leds <= (r_leds & ~w_wm) | (w_wd & w_wm);
      // OR-ing the change pulses after the clear makes a same-cycle set win
      r_flags <= (r_flags & ~(w_we_flags ? (w_wd & w_wm) : '0)) | w_change;
    end
  end

  assign Leds = r_leds;

endmodule
